uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and
// default constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } arb_state_e;

  localparam int NUM_REQ_DEF      = 4;
  localparam int GAP_CYCLES_DEF   = 1024;
  localparam int BUSY_TIMEOUT_DEF = 65535;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick,
// scanning upward from last_i+1 with wrap to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // first requester after last_i wins
  always_comb begin
    logic found;
    int   j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j] && !found) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: one-deep byte slots per requester,
// round-robin feed of a single external UART transmitter.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                 clk_65mhz,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   req_overflow,
  output logic [NUM_REQ-1:0]   pending,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 tx_timeout
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (GAP_CYCLES > BUSY_TIMEOUT) ?
                        GAP_CYCLES : BUSY_TIMEOUT;
  localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_SAT  = CW'(CMAX);
  localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam arb_state_e POST =
    (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

  arb_state_e state_q, state_d;

  logic                    run_q;
  logic [NUM_REQ-1:0]      pend_q, pend_d;
  logic [NUM_REQ-1:0]      ovf_q, ovf_d;
  logic [NUM_REQ-1:0]      acc, clr;
  logic [NUM_REQ-1:0][7:0] data_q;
  logic [7:0]              txd_q, txd_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [IW-1:0]           last_q, last_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rr_gnt;
  logic [IW-1:0]           rr_idx;
  logic [7:0]              rr_byte;
  logic                    done, start, tmo;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i  (pend_q),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx)
  );

  // retime reset release so the first grant lands on the second edge
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // byte held by the slot the arbiter would grant now
  always_comb begin
    rr_byte = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rr_byte = rr_byte | (data_q[i] & {8{rr_gnt[i]}});
  end

  // slot bookkeeping: a completing slot may be refilled in the same cycle
  always_comb begin
    clr    = done ? (NUM_REQ'(1) << grant_q) : '0;
    acc    = req_valid & (~pend_q | clr);
    pend_d = (pend_q & ~clr) | acc;
    ovf_d  = req_valid & pend_q & ~clr;
  end

  // frame sequencing: grant, strobe, wait for busy, wait for done, gap
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    txd_d   = txd_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    tmo     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_q && (|pend_q)) begin
          grant_d = rr_idx;
          txd_d   = rr_byte;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tx_busy) begin
          start   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo     = 1'b1;
          cnt_d   = '0;
          state_d = POST;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          done    = 1'b1;
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = POST;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control state registers
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ovf_q   <= '0;
      txd_q   <= '0;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      txd_q   <= txd_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // slot data: written only when a request is accepted
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (acc[i]) data_q[i] <= req_data[8*i +: 8];
    end
  end

  assign pending      = pend_q;
  assign req_overflow = ovf_q;
  assign req_ack      = clr;
  assign tx_start     = start;
  assign tx_timeout   = tmo;
  assign tx_data      = txd_q;

endmodule
